ioctl_ddram_loader: RTL and testbench

IOCTL_DDRAM_LOADER -- requirements
Module: ioctl_ddram_loader

---
 rtl/ioctl_ddram_loader.sv | 181 ++++++++++++++++++
 tb/tb_ioctl_ddram_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_ddram_loader.sv
// Packs an ioctl byte-stream download into 64-bit DDRAM word writes at a per-slot base, through a small write FIFO.
// Optional build macro LOADER_CSUM_EN enables a 16-bit running byte checksum on load_csum.
module ioctl_ddram_loader #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter logic [28:0] BASE_WORD  = 29'h0100000,
  parameter logic [28:0] SLOT_WORDS = 29'h0080000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        ddram_busy,
  output logic        ddram_we,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic [7:0]  ddram_burstcnt,
  output logic        load_done,
  output logic        load_err,
  output logic [24:0] load_size,
  output logic [15:0] load_csum
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } word_t;

  state_t        state_q, state_d;
  logic          dl_q;
  logic [28:0]   slot_base_q;
  logic [63:0]   pk_data_q, pk_data_d;
  logic [7:0]    pk_be_q, pk_be_d;
  logic [21:0]   pk_wa_q, pk_wa_d;
  word_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  word_t         push_word, head_d;
  logic          push, push_ok, pop, accept, load_start;
  logic [2:0]    lane;
  logic [21:0]   new_wa;

  assign ddram_burstcnt = 8'd1;
  assign lane       = ioctl_addr[2:0];
  assign new_wa     = ioctl_addr[24:3];
  assign load_start = (state_q == IDLE) && ioctl_download && !dl_q;
  assign accept     = (state_q == LOAD) && ioctl_wr && !load_err;
  assign pop        = ddram_we && !ddram_busy;

  // Control FSM: download edges drive LOAD/FLUSH; DONE waits for the write path to drain.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (dl_q && !ioctl_download) state_d = FLUSH;
      FLUSH:   if (pk_be_q == 8'h00 && count_q == '0 && !ddram_we) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte packer: a word leaves when lane 7 fills, the word address changes, or on flush.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    pk_data_d = pk_data_q;
    pk_be_d   = pk_be_q;
    pk_wa_d   = pk_wa_q;
    if (accept) begin
      if (pk_be_q != 8'h00 && new_wa != pk_wa_q) begin
        push           = 1'b1;
        push_word.addr = slot_base_q + 29'(pk_wa_q);
        push_word.data = pk_data_q;
        push_word.be   = pk_be_q;
        pk_data_d      = '0;
        pk_be_d        = '0;
      end
      pk_wa_d                        = new_wa;
      pk_data_d[{lane, 3'b000} +: 8] = ioctl_dout;
      pk_be_d[lane]                  = 1'b1;
      if (lane == 3'd7 && !push) begin
        push           = 1'b1;
        push_word.addr = slot_base_q + 29'(new_wa);
        push_word.data = pk_data_d;
        push_word.be   = pk_be_d;
        pk_data_d      = '0;
        pk_be_d        = '0;
      end
    end else if (state_q == FLUSH && pk_be_q != 8'h00) begin
      push           = 1'b1;
      push_word.addr = slot_base_q + 29'(pk_wa_q);
      push_word.data = pk_data_q;
      push_word.be   = pk_be_q;
      pk_data_d      = '0;
      pk_be_d        = '0;
    end
  end

  // FIFO bookkeeping; the registered head is the next word in line after this edge.
  always_comb begin
    push_ok  = push && (count_q != CW'(FIFO_DEPTH) || pop);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    head_d   = '0;
    if (count_d != '0) begin
      if ((count_q - CW'(pop)) == '0) head_d = push_word;
      else                            head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      slot_base_q <= '0;
      pk_data_q   <= '0;
      pk_be_q     <= '0;
      pk_wa_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ioctl_wait  <= 1'b0;
      ddram_we    <= 1'b0;
      ddram_addr  <= '0;
      ddram_din   <= '0;
      ddram_be    <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      load_size   <= '0;
    end else begin
      dl_q       <= ioctl_download;
      pk_data_q  <= pk_data_d;
      pk_be_q    <= pk_be_d;
      pk_wa_q    <= pk_wa_d;
      wr_ptr_q   <= wr_ptr_q + PW'(push_ok);
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ioctl_wait <= count_d >= CW'(FIFO_DEPTH - 1);
      ddram_we   <= count_d != '0;
      ddram_addr <= head_d.addr;
      ddram_din  <= head_d.data;
      ddram_be   <= head_d.be;
      load_done  <= state_d == DONE;
      if (load_start) begin
        slot_base_q <= BASE_WORD + 29'(ioctl_index) * SLOT_WORDS;
        load_err    <= 32'(ioctl_index) >= NUM_SLOTS;
        load_size   <= '0;
      end else if (accept && (26'(ioctl_addr) + 26'd1) > 26'(load_size)) begin
        load_size <= ioctl_addr + 25'd1;
      end
    end
  end

`ifdef LOADER_CSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        load_csum <= '0;
    else if (load_start) load_csum <= '0;
    else if (accept)     load_csum <= load_csum + 16'(ioctl_dout);
  end
`else
  assign load_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_ioctl_ddram_loader.sv
// Scoreboard bench for ioctl_ddram_loader: expected DDRAM words queued at stimulus time, checked at each accepted write.
module tb_ioctl_ddram_loader;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait;
  logic        ddram_busy, ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be, ddram_burstcnt;
  logic        load_done, load_err;
  logic [24:0] load_size;
  logic [15:0] load_csum;

  typedef struct packed {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  b;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   wr_cnt = 0, done_cnt = 0, bytes_sent = 0, sent_at_wait = -1;

  always #5 clk_sys = ~clk_sys;

  ioctl_ddram_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .ddram_busy(ddram_busy), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_burstcnt(ddram_burstcnt),
    .load_done(load_done), .load_err(load_err), .load_size(load_size), .load_csum(load_csum)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: a word presented with busy low is taken at the next rising edge.
  always @(negedge clk_sys) begin
    if (load_done) done_cnt++;
    if (ioctl_wait && sent_at_wait < 0) sent_at_wait = bytes_sent;
    if (reset_n && ddram_we && !ddram_busy) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_write", 64'(ddram_addr), 64'h1FFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("wr_addr", 64'(ddram_addr), 64'(e.a));
        check_eq("wr_din", ddram_din, e.d);
        check_eq("wr_be", 64'(ddram_be), 64'(e.b));
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int guard = 0;
    while (ioctl_wait && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) check_eq("wait_timeout", 64'(guard), 64'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    bytes_sent++;
  endtask

  task automatic end_load();
    int n = 0;
    ioctl_download = 1'b0;
    while (!load_done && n < 2000) begin
      tick();
      n++;
    end
    check_eq("done_seen", 64'(load_done), 64'd1);
    repeat (3) tick();
  endtask

  function automatic exp_t mk(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
    exp_t e;
    e.a = a; e.d = d; e.b = b;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    logic [7:0]  rb [64];
    logic [63:0] wd;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ddram_busy = 1'b0;
    repeat (3) tick();
    check_eq("rst_we", 64'(ddram_we), 64'd0);
    check_eq("rst_wait", 64'(ioctl_wait), 64'd0);
    check_eq("rst_addr", 64'(ddram_addr), 64'd0);
    check_eq("rst_din", ddram_din, 64'd0);
    check_eq("rst_be", 64'(ddram_be), 64'd0);
    check_eq("rst_done", 64'(load_done), 64'd0);
    check_eq("rst_err", 64'(load_err), 64'd0);
    check_eq("rst_size", 64'(load_size), 64'd0);
    check_eq("rst_csum", 64'(load_csum), 64'd0);
    check_eq("burstcnt", 64'(ddram_burstcnt), 64'd1);
    reset_n = 1'b1;
    tick();

    // Full word, slot 0
    w0 = wr_cnt; d0 = done_cnt;
    sb.push_back(mk(29'h0100000, 64'h0807060504030201, 8'hFF));
    start_load(8'd0);
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(i + 1));
    end_load();
    check_eq("t1_writes", 64'(wr_cnt - w0), 64'd1);
    check_eq("t1_size", 64'(load_size), 64'd8);
    check_eq("t1_done", 64'(done_cnt - d0), 64'd1);

    // Partial word flushed on download end, slot 1
    w0 = wr_cnt; d0 = done_cnt;
    sb.push_back(mk(29'h0180000, 64'h0000_0000_00CC_BBAA, 8'h07));
    start_load(8'd1);
    send_byte(25'd0, 8'hAA); send_byte(25'd1, 8'hBB); send_byte(25'd2, 8'hCC);
    end_load();
    check_eq("t2_writes", 64'(wr_cnt - w0), 64'd1);
    check_eq("t2_size", 64'(load_size), 64'd3);
    check_eq("t2_done", 64'(done_cnt - d0), 64'd1);
    check_eq("t2_err", 64'(load_err), 64'd0);

    // Word address jump pushes the old word first, slot 3
    w0 = wr_cnt;
    sb.push_back(mk(29'h0280002, 64'h0000_0000_0000_6B5A, 8'h03));
    sb.push_back(mk(29'h0280004, 64'h0000_0000_7C00_0000, 8'h08));
    start_load(8'd3);
    send_byte(25'h10, 8'h5A); send_byte(25'h11, 8'h6B); send_byte(25'h23, 8'h7C);
    end_load();
    check_eq("t3_writes", 64'(wr_cnt - w0), 64'd2);
    check_eq("t3_size", 64'(load_size), 64'h24);

    // 64 bytes against a stalled DDRAM: backpressure at 7 queued words, then in-order drain
    w0 = wr_cnt; bytes_sent = 0; sent_at_wait = -1;
    for (int i = 0; i < 64; i++) rb[i] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 8; w++) begin
      wd = '0;
      for (int k = 0; k < 8; k++) wd[8*k +: 8] = rb[8*w + k];
      sb.push_back(mk(29'h0200000 + 29'(w), wd, 8'hFF));
    end
    ddram_busy = 1'b1;
    fork
      begin
        start_load(8'd2);
        for (int i = 0; i < 64; i++) send_byte(25'(i), rb[i]);
        end_load();
      end
      begin
        repeat (80) tick();
        ddram_busy = 1'b0;
      end
    join
    check_eq("t4_wait_at_7", 64'(sent_at_wait), 64'd56);
    check_eq("t4_writes", 64'(wr_cnt - w0), 64'd8);
    check_eq("t4_size", 64'(load_size), 64'd64);
    check_eq("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Out-of-range index: no writes, error flag, done still pulses
    w0 = wr_cnt; d0 = done_cnt;
    start_load(8'd5);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(8'h40 + i));
    end_load();
    check_eq("t5_writes", 64'(wr_cnt - w0), 64'd0);
    check_eq("t5_err", 64'(load_err), 64'd1);
    check_eq("t5_done", 64'(done_cnt - d0), 64'd1);
    check_eq("t5_size", 64'(load_size), 64'd0);

    // Checksum and error clearing on the next download
    sb.push_back(mk(29'h0100000, 64'h0000_0000_0002_FFFF, 8'h07));
    start_load(8'd0);
    check_eq("t6_err_clr", 64'(load_err), 64'd0);
    send_byte(25'd0, 8'hFF); send_byte(25'd1, 8'hFF); send_byte(25'd2, 8'h02);
    end_load();
`ifdef LOADER_CSUM_EN
    check_eq("t6_csum", 64'(load_csum), 64'h0200);
`else
    check_eq("t6_csum", 64'(load_csum), 64'h0000);
`endif

    // Reset while a write is stalled: the word is discarded
    w0 = wr_cnt;
    ddram_busy = 1'b1;
    start_load(8'd0);
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(8'hA0 + i));
    repeat (2) tick();
    check_eq("t7_we_pre", 64'(ddram_we), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t7_we_rst", 64'(ddram_we), 64'd0);
    check_eq("t7_be_rst", 64'(ddram_be), 64'd0);
    check_eq("t7_wait_rst", 64'(ioctl_wait), 64'd0);
    ioctl_download = 1'b0;
    tick();
    ddram_busy = 1'b0;
    reset_n = 1'b1;
    repeat (20) tick();
    check_eq("t7_writes", 64'(wr_cnt - w0), 64'd0);
    check_eq("t7_size", 64'(load_size), 64'd0);
    check_eq("t7_done", 64'(load_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
